// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and
// inter-stage bundle types.
package mips_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF   = 32'h0000_0001;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_next;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/pc_unit.sv
// Program counter register and next-PC
// select for the fetch stage.
module pc_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  assign pc      = pc_q;
  assign pc_plus = pc_q + PC_STEP;

  // Redirects beat stall so a resolved
  // transfer is never dropped.
  always_comb begin
    pc_d = pc_plus;
    if (jump) begin
      pc_d = jump_target;
    end else if (branch_taken) begin
      pc_d = branch_target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: drives imem from the PC
// and registers the fetched word into IF/ID.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP   = PC_STEP_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc_next,
  output logic            if_id_valid
);

  logic [XLEN-1:0] pc_plus;
  if_id_t          if_id_d;
  if_id_t          if_id_q;
  if_id_t          bubble;

  pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_plus       (pc_plus)
  );

  assign imem_addr = pc;

  assign bubble.instr   = NOP_INSTR;
  assign bubble.pc_next = '0;
  assign bubble.valid   = 1'b0;

  // Flush beats stall: a squashed slot
  // becomes a bubble even while held.
  always_comb begin
    if_id_d.instr   = imem_rdata;
    if_id_d.pc_next = pc_plus;
    if_id_d.valid   = 1'b1;
    if (flush) begin
      if_id_d = bubble;
    end else if (stall) begin
      if_id_d = if_id_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q <= bubble;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_instr   = if_id_q.instr;
  assign if_id_pc_next = if_id_q.pc_next;
  assign if_id_valid   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for
// fetch_stage with a modelled inst_memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_next;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_next (if_id_pc_next),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(
    input logic [31:0] a
  );
    return (a ^ 32'hDEAD_0000) + 32'h0100_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(
    input string       tag,
    input logic [31:0] p,
    input logic [31:0] ins,
    input logic [31:0] pn,
    input logic        v
  );
    check({tag, ".pc"}, pc, p);
    check({tag, ".addr"}, imem_addr, p);
    check({tag, ".instr"}, if_id_instr, ins);
    check({tag, ".pcn"}, if_id_pc_next, pn);
    check({tag, ".v"}, {31'b0, if_id_valid},
          {31'b0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    jump = 1'b0;
    jump_target = '0;
    step();
    step();
    ifid("rst", 0, NOP, 0, 0);
    reset = 1'b0;
    step();
    ifid("s1a", 1, mem(0), 1, 1);
    step();
    ifid("s1b", 2, mem(1), 2, 1);
    step();
    ifid("s1c", 3, mem(2), 3, 1);
    step();
    step();
    ifid("pre2", 5, mem(4), 5, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ifid("stall", 5, mem(4), 5, 1);
    end
    stall = 1'b0;
    step();
    ifid("unst", 6, mem(5), 6, 1);
    step();
    check("pre3.pc", pc, 7);
    branch_taken = 1'b1;
    branch_target = 32'h10;
    flush = 1'b1;
    step();
    ifid("br", 32'h10, NOP, 0, 0);
    branch_taken = 1'b0;
    flush = 1'b0;
    step();
    ifid("br2", 32'h11, mem(32'h10), 32'h11, 1);
    jump = 1'b1;
    jump_target = 32'h3;
    branch_taken = 1'b1;
    branch_target = 32'h20;
    stall = 1'b1;
    step();
    ifid("jmp", 3, mem(32'h10), 32'h11, 1);
    jump = 1'b0;
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    ifid("jmp2", 4, mem(3), 4, 1);
    flush = 1'b1;
    stall = 1'b1;
    step();
    ifid("fs", 4, NOP, 0, 0);
    flush = 1'b0;
    step();
    ifid("fs_hold", 4, NOP, 0, 0);
    stall = 1'b0;
    step();
    ifid("fs_rel", 5, mem(4), 5, 1);
    repeat (4) step();
    check("pre5.pc", pc, 9);
    stall = 1'b1;
    step();
    check("st9.pc", pc, 9);
    #2;
    reset = 1'b1;
    #1;
    ifid("arst", 0, NOP, 0, 0);
    @(posedge clk);
    #1;
    ifid("arst_hold", 0, NOP, 0, 0);
    reset = 1'b0;
    stall = 1'b0;
    step();
    ifid("rel5", 1, mem(0), 1, 1);
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFF;
    step();
    ifid("jmax", 32'hFFFF_FFFF, mem(1), 2, 1);
    jump = 1'b0;
    step();
    ifid("wrap", 0, mem(32'hFFFF_FFFF), 0, 1);
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule
